// File: rtl/hv_bist_ctrl_if.sv
// Signal bundle between the HV BIST sequencer and its neighbours
// (hv_abist, LBIST engine, HV register/fault logic).
interface hv_bist_ctrl_if;
  logic       i_bist_req;
  logic       i_pwr_rdy;
  logic [5:0] i_abist_status;
  logic       i_lbist_en;
  logic       i_lbist_done;
  logic       i_lbist_pass;
  logic       o_bist_en;
  logic       o_bist_busy;
  logic       o_bist_done;
  logic       o_bist_fail;
  logic [8:0] o_bist_rslt;

  modport master (
    input  i_bist_req, i_pwr_rdy, i_abist_status, i_lbist_en, i_lbist_done, i_lbist_pass,
    output o_bist_en, o_bist_busy, o_bist_done, o_bist_fail, o_bist_rslt
  );

  modport slave (
    output i_bist_req, i_pwr_rdy, i_abist_status, i_lbist_en, i_lbist_done, i_lbist_pass,
    input  o_bist_en, o_bist_busy, o_bist_done, o_bist_fail, o_bist_rslt
  );
endinterface

// File: rtl/hv_bist_ctrl.sv
// HV-side BIST sequencer: settles the supply, runs analog BIST via hv_abist, hands over to
// LBIST, and publishes a latched 9-bit result word with done/fail flags.
module hv_bist_ctrl #(
  parameter int unsigned CLK_M       = 48,
  parameter int unsigned SETTLE_US   = 10,
  parameter int unsigned ABIST_TO_US = 200,
  parameter int unsigned LBIST_TO_US = 500,
  parameter bit          AUTO_START  = 1'b1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  hv_bist_ctrl_if.master bus
);

  localparam int unsigned SettleCyc  = SETTLE_US * CLK_M;
  localparam int unsigned AbistToCyc = ABIST_TO_US * CLK_M;
  localparam int unsigned LbistToCyc = LBIST_TO_US * CLK_M;
  localparam int unsigned MaxCyc =
      (SettleCyc > AbistToCyc) ? ((SettleCyc > LbistToCyc) ? SettleCyc : LbistToCyc)
                               : ((AbistToCyc > LbistToCyc) ? AbistToCyc : LbistToCyc);
  localparam int unsigned CntW = $clog2(MaxCyc + 1);

  localparam logic [CntW-1:0] SettleLast  = CntW'(SettleCyc - 1);
  localparam logic [CntW-1:0] AbistToLast = CntW'(AbistToCyc - 1);
  localparam logic [CntW-1:0] LbistToLast = CntW'(LbistToCyc - 1);
  localparam logic [CntW-1:0] CntMax      = '1;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSettle = 3'd1;
  localparam logic [2:0] StAbist  = 3'd2;
  localparam logic [2:0] StLbist  = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [8:0]      rslt_q, rslt_d;
  logic            fail_q, fail_d;
  logic            bist_en_q, bist_en_d;
  logic            req_q;
  logic            auto_q, auto_d;
  logic            start;
  logic            start_taken;
  logic            counting;

  assign start       = (bus.i_bist_req & ~req_q) | (auto_q & bus.i_pwr_rdy);
  assign start_taken = (state_q == StIdle) & start;
  assign counting    = (state_q == StSettle) | (state_q == StAbist) | (state_q == StLbist);

  always_comb begin
    state_d = state_q;
    rslt_d  = rslt_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSettle;
          rslt_d  = '0;
        end
      end
      StSettle: begin
        if (bus.i_pwr_rdy && cnt_q == SettleLast) state_d = StAbist;
      end
      StAbist: begin
        // Power loss wins over capture and timeout; uncaptured status stays 0.
        if (!bus.i_pwr_rdy) begin
          rslt_d[8] = 1'b1;
          state_d   = StDone;
        end else if (bus.i_lbist_en) begin
          rslt_d[5:0] = bus.i_abist_status;
          state_d     = StLbist;
        end else if (cnt_q == AbistToLast) begin
          rslt_d[7]   = 1'b1;
          rslt_d[5:0] = bus.i_abist_status;
          state_d     = StDone;
        end
      end
      StLbist: begin
        if (!bus.i_pwr_rdy) begin
          rslt_d[8] = 1'b1;
          state_d   = StDone;
        end else if (bus.i_lbist_done) begin
          rslt_d[6] = ~bus.i_lbist_pass;
          state_d   = StDone;
        end else if (cnt_q == LbistToLast) begin
          rslt_d[7:6] = 2'b11;
          state_d     = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == StSettle && !bus.i_pwr_rdy) begin
      cnt_d = '0;
    end else if (counting && cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    fail_d = fail_q;
    if (start_taken) begin
      fail_d = 1'b0;
    end else if (state_d == StDone) begin
      fail_d = |rslt_d;
    end
  end

  assign auto_d    = start_taken ? 1'b0 : auto_q;
  assign bist_en_d = (state_d == StAbist) | (state_d == StLbist);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rslt_q    <= '0;
      fail_q    <= 1'b0;
      bist_en_q <= 1'b0;
      req_q     <= 1'b0;
      auto_q    <= AUTO_START;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rslt_q    <= rslt_d;
      fail_q    <= fail_d;
      bist_en_q <= bist_en_d;
      req_q     <= bus.i_bist_req;
      auto_q    <= auto_d;
    end
  end

  assign bus.o_bist_en   = bist_en_q;
  assign bus.o_bist_busy = (state_q != StIdle);
  assign bus.o_bist_done = (state_q == StDone);
  assign bus.o_bist_fail = fail_q;
  assign bus.o_bist_rslt = rslt_q;

endmodule

// File: tb/tb_hv_bist_ctrl.sv
// Directed bench for hv_bist_ctrl at CLK_M=4: settle 40, ABIST timeout 800, LBIST timeout 2000
// cycles. A second instance built with AUTO_START=0 checks the manual-start path.
module tb_hv_bist_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hv_bist_ctrl_if bif ();
  hv_bist_ctrl_if bif0 ();

  hv_bist_ctrl #(
    .CLK_M      (4),
    .SETTLE_US  (10),
    .ABIST_TO_US(200),
    .LBIST_TO_US(500),
    .AUTO_START (1'b1)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bif)
  );

  hv_bist_ctrl #(
    .CLK_M      (4),
    .SETTLE_US  (10),
    .ABIST_TO_US(200),
    .LBIST_TO_US(500),
    .AUTO_START (1'b0)
  ) dut0 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bif0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Rising edge on i_bist_req from IDLE; returns at the first ABIST negedge.
  task automatic start_run(input string tag);
    bif.i_bist_req = 1'b1;
    cyc(1);
    bif.i_bist_req = 1'b0;
    chk({tag, "_clear"}, {21'd0, bif.o_bist_fail, bif.o_bist_busy, bif.o_bist_rslt}, 32'h200);
    cyc(39);
    chk({tag, "_en_low"}, {31'd0, bif.o_bist_en}, 32'd0);
    cyc(1);
    chk({tag, "_en_rise"}, {31'd0, bif.o_bist_en}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.i_bist_req      = 1'b0;
    bif.i_pwr_rdy       = 1'b1;
    bif.i_abist_status  = 6'h00;
    bif.i_lbist_en      = 1'b0;
    bif.i_lbist_done    = 1'b0;
    bif.i_lbist_pass    = 1'b0;
    bif0.i_bist_req     = 1'b0;
    bif0.i_pwr_rdy      = 1'b1;
    bif0.i_abist_status = 6'h00;
    bif0.i_lbist_en     = 1'b0;
    bif0.i_lbist_done   = 1'b0;
    bif0.i_lbist_pass   = 1'b0;
    #1 rst_n = 1'b0;
    cyc(3);
    chk("rst_outputs", {19'd0, bif.o_bist_en, bif.o_bist_busy, bif.o_bist_done,
        bif.o_bist_fail, bif.o_bist_rslt}, 32'd0);

    // Auto start: settle 40 cycles, LBIST handover at ABIST cycle 600, pass 100 later.
    rst_n = 1'b1;
    cyc(1);
    chk("auto_busy", {31'd0, bif.o_bist_busy}, 32'd1);
    chk("auto_en_low", {31'd0, bif.o_bist_en}, 32'd0);
    cyc(39);
    chk("auto_en_40", {31'd0, bif.o_bist_en}, 32'd0);
    chk("noauto_idle", {31'd0, bif0.o_bist_busy}, 32'd0);
    cyc(1);
    chk("auto_en_41", {31'd0, bif.o_bist_en}, 32'd1);
    cyc(599);
    bif.i_lbist_en = 1'b1;
    cyc(1);
    chk("lbist_en_busy", {30'd0, bif.o_bist_en, bif.o_bist_busy}, 32'd3);
    cyc(99);
    chk("lbist_wait", {31'd0, bif.o_bist_done}, 32'd0);
    bif.i_lbist_done = 1'b1;
    bif.i_lbist_pass = 1'b1;
    cyc(1);
    bif.i_lbist_done = 1'b0;
    bif.i_lbist_en   = 1'b0;
    chk("pass_done", {31'd0, bif.o_bist_done}, 32'd1);
    chk("pass_rslt", {23'd0, bif.o_bist_rslt}, 32'h000);
    chk("pass_fail_en", {30'd0, bif.o_bist_fail, bif.o_bist_en}, 32'd0);
    cyc(1);
    chk("pass_idle", {30'd0, bif.o_bist_done, bif.o_bist_busy}, 32'd0);

    // Failing analog items captured at handover; later status changes ignored.
    start_run("r2");
    bif.i_abist_status = 6'b001010;
    bif.i_lbist_en     = 1'b1;
    cyc(1);
    bif.i_abist_status = 6'b110101;
    cyc(5);
    bif.i_lbist_done = 1'b1;
    bif.i_lbist_pass = 1'b1;
    cyc(1);
    bif.i_lbist_done = 1'b0;
    chk("stat_rslt", {23'd0, bif.o_bist_rslt}, 32'h00A);
    chk("stat_fail_done", {30'd0, bif.o_bist_fail, bif.o_bist_done}, 32'd3);
    cyc(1);
    chk("stat_hold", {22'd0, bif.o_bist_fail, bif.o_bist_rslt}, 32'h20A);
    bif.i_lbist_en     = 1'b0;
    bif.i_abist_status = 6'h00;

    // ABIST timeout with a status snapshot.
    start_run("r3");
    bif.i_abist_status = 6'h01;
    cyc(799);
    chk("ato_pre", {30'd0, bif.o_bist_en, bif.o_bist_done}, 32'd2);
    cyc(1);
    chk("ato_done", {31'd0, bif.o_bist_done}, 32'd1);
    chk("ato_rslt", {22'd0, bif.o_bist_fail, bif.o_bist_rslt}, 32'h281);
    bif.i_abist_status = 6'h00;
    cyc(1);

    // LBIST timeout.
    start_run("r4");
    bif.i_lbist_en = 1'b1;
    cyc(1);
    cyc(1999);
    chk("lto_pre", {30'd0, bif.o_bist_en, bif.o_bist_done}, 32'd2);
    cyc(1);
    chk("lto_done", {31'd0, bif.o_bist_done}, 32'd1);
    chk("lto_rslt", {22'd0, bif.o_bist_fail, bif.o_bist_rslt}, 32'h2C0);
    bif.i_lbist_en = 1'b0;
    cyc(1);

    // Supply dip during SETTLE restarts the settle count.
    bif.i_bist_req = 1'b1;
    cyc(1);
    bif.i_bist_req = 1'b0;
    cyc(20);
    bif.i_pwr_rdy = 1'b0;
    cyc(5);
    chk("dip_hold", {30'd0, bif.o_bist_en, bif.o_bist_busy}, 32'd1);
    bif.i_pwr_rdy = 1'b1;
    cyc(39);
    chk("dip_en_39", {31'd0, bif.o_bist_en}, 32'd0);
    cyc(1);
    chk("dip_en_40", {31'd0, bif.o_bist_en}, 32'd1);

    // Power loss during LBIST.
    bif.i_lbist_en = 1'b1;
    cyc(11);
    bif.i_pwr_rdy = 1'b0;
    cyc(1);
    chk("pabort_done", {30'd0, bif.o_bist_done, bif.o_bist_en}, 32'd2);
    chk("pabort_rslt", {22'd0, bif.o_bist_fail, bif.o_bist_rslt}, 32'h300);
    bif.i_pwr_rdy  = 1'b1;
    bif.i_lbist_en = 1'b0;
    cyc(1);

    // Request edges while busy are dropped; LBIST verdict fail.
    start_run("r6");
    bif.i_bist_req = 1'b1;
    cyc(1);
    bif.i_bist_req = 1'b0;
    bif.i_lbist_en = 1'b1;
    cyc(1);
    bif.i_lbist_done = 1'b1;
    bif.i_lbist_pass = 1'b0;
    cyc(1);
    bif.i_lbist_done = 1'b0;
    bif.i_lbist_en   = 1'b0;
    chk("lfail_rslt", {22'd0, bif.o_bist_fail, bif.o_bist_rslt}, 32'h240);
    cyc(1);
    chk("noqueue_0", {31'd0, bif.o_bist_busy}, 32'd0);
    cyc(3);
    chk("noqueue_3", {31'd0, bif.o_bist_busy}, 32'd0);

    // New edge clears the result; then asynchronous reset mid-ABIST.
    start_run("r7");
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {19'd0, bif.o_bist_en, bif.o_bist_busy, bif.o_bist_done,
        bif.o_bist_fail, bif.o_bist_rslt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    chk("rearm_busy", {31'd0, bif.o_bist_busy}, 32'd1);
    chk("noauto_after_rst", {31'd0, bif0.o_bist_busy}, 32'd0);

    // AUTO_START=0 instance only runs on a request edge.
    bif0.i_bist_req = 1'b1;
    cyc(1);
    bif0.i_bist_req = 1'b0;
    chk("manual_busy", {30'd0, bif0.o_bist_en, bif0.o_bist_busy}, 32'd1);
    cyc(40);
    chk("manual_en", {31'd0, bif0.o_bist_en}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
